// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared RV32I decode definitions: major opcodes, immediate
//               formats and the opcode-to-immediate-format mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    // R-type and unknown opcodes carry no immediate; they fall back to the
    // I layout so the field is still deterministic for execute.
    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        imm_type_e t;
        case (opcode)
            STORE:      t = IMM_S;
            BRANCH:     t = IMM_B;
            LUI, AUIPC: t = IMM_U;
            JAL:        t = IMM_J;
            default:    t = IMM_I;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : Combinational RV32I immediate generator. Selects the I/S/B/U/J
//               layout from the opcode and sign-extends from instr[31].
// Ports       : instr  in  32    instruction word
//               imm    out XLEN  sign-extended immediate
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = 32'd0;
        case (imm_type_of(instr[6:0]))
            IMM_S:   imm32 = {{21{instr[31]}}, instr[30:25], instr[11:7]};
            IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'd0};
            IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = {{21{instr[31]}}, instr[30:20]};
        endcase
        imm = XLEN'($signed(imm32));
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : RV32I decode / operand-fetch stage. Drives register file read
//               addresses, builds the immediate, tracks in-flight destinations
//               in a busy scoreboard (stalls on RAW/WAW), and registers the
//               decoded bundle into ID/EX behind a valid/ready handshake.
// Ports       : clk, rst                      clock, sync active-high reset
//               if_valid/if_ready/if_instr/if_pc   fetch handshake + payload
//               rf_raddr1/2 out, rf_rdata1/2 in    register file read port
//               wb_valid, wb_rd               writeback commit (clears busy)
//               flush                         kill younger work
//               ex_valid/ex_ready             ID/EX handshake
//               ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_wen
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int NREGS = 32,
    localparam int RA   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [RA-1:0]   rf_raddr1,
    output logic [RA-1:0]   rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_valid,
    input  logic [RA-1:0]   wb_rd,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [31:0]     ex_instr,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [RA-1:0]   ex_rd,
    output logic            ex_wen
);

    logic [6:0]       opcode;
    logic [RA-1:0]    rd, rs1, rs2;
    logic             legal, uses_rs1, uses_rs2, writes_rd;
    logic             clr_rs1, clr_rs2, clr_rd;
    logic             hazard, accept, kill_clr;
    logic [NREGS-1:0] busy, busy_next;
    logic [XLEN-1:0]  imm;

    assign opcode    = if_instr[6:0];
    assign rd        = RA'(if_instr[11:7]);
    assign rs1       = RA'(if_instr[19:15]);
    assign rs2       = RA'(if_instr[24:20]);
    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;

    always_comb begin
        case (opcode)
            OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC: legal = 1'b1;
            default:                                                legal = 1'b0;
        endcase
        uses_rs1  = !(opcode == LUI || opcode == AUIPC || opcode == JAL);
        uses_rs2  = (opcode == OP || opcode == STORE || opcode == BRANCH);
        // Unknown opcodes must not claim a destination: execute traps them.
        writes_rd = legal && (opcode != STORE) && (opcode != BRANCH) && (rd != '0);
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (if_instr),
        .imm   (imm)
    );

    // A busy bit being cleared by writeback this cycle is not a hazard: the
    // register file bypasses the write data onto rf_rdata in the same cycle.
    assign clr_rs1 = wb_valid && (wb_rd == rs1) && (rs1 != '0);
    assign clr_rs2 = wb_valid && (wb_rd == rs2) && (rs2 != '0);
    assign clr_rd  = wb_valid && (wb_rd == rd)  && (rd  != '0);

    assign hazard = if_valid && ((uses_rs1  && busy[rs1] && !clr_rs1) ||
                                 (uses_rs2  && busy[rs2] && !clr_rs2) ||
                                 (writes_rd && busy[rd]  && !clr_rd));

    assign if_ready = !flush && !hazard && (!ex_valid || ex_ready);
    assign accept   = if_valid && if_ready;

    // A stalled entry killed by flush never reaches writeback, so its busy bit
    // would otherwise never be released.
    assign kill_clr = flush && ex_valid && !ex_ready && ex_wen;

    always_comb begin
        busy_next = busy;
        if (wb_valid) begin
            busy_next[wb_rd] = 1'b0;
        end
        if (kill_clr) begin
            busy_next[ex_rd] = 1'b0;
        end
        if (accept && writes_rd) begin
            busy_next[rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_instr   <= '0;
            ex_rs1_val <= '0;
            ex_rs2_val <= '0;
            ex_imm     <= '0;
            ex_rd      <= '0;
            ex_wen     <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid   <= 1'b1;
            ex_pc      <= if_pc;
            ex_instr   <= if_instr;
            ex_rs1_val <= rf_rdata1;
            ex_rs2_val <= rf_rdata2;
            ex_imm     <= imm;
            ex_rd      <= rd;
            ex_wen     <= writes_rd;
        end else if (ex_valid && ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage. Directed scenarios with
//               literal expectations followed by randomized traffic checked
//               every cycle against a behavioural model of the stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_wen;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_wen(ex_wen)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct {
        bit [31:0] pc, instr, rs1v, rs2v, imm;
        bit [4:0]  rd;
        bit        wen;
    } bundle_t;

    bit      model_ok = 0;
    bit      m_busy[32];
    bit      m_valid;
    bundle_t m_ex;

    function automatic bit [31:0] busy_vec();
        bit [31:0] v = 0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) v |= (32'd1 << i);
        return v;
    endfunction

    // Decode rules and immediates written from the ISA definition with
    // shift/mask arithmetic.
    function automatic void mdec(input bit [31:0] ins, output bit u1, output bit u2,
                                 output bit wr, output bit [31:0] imm);
        bit [6:0]  opc  = ins[6:0];
        bit [31:0] sext = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        bit        legal;
        legal = (opc == 7'h33) || (opc == 7'h13) || (opc == 7'h03) || (opc == 7'h23) ||
                (opc == 7'h63) || (opc == 7'h6F) || (opc == 7'h67) || (opc == 7'h37) ||
                (opc == 7'h17);
        u1 = !(opc == 7'h37 || opc == 7'h17 || opc == 7'h6F);
        u2 = (opc == 7'h33 || opc == 7'h23 || opc == 7'h63);
        wr = legal && opc != 7'h23 && opc != 7'h63 && ins[11:7] != 0;
        case (opc)
            7'h23: imm = (sext << 11) | ({25'd0, ins[31:25]} << 5) | {27'd0, ins[11:7]};
            7'h63: imm = (sext << 12) | ({31'd0, ins[7]} << 11) | ({26'd0, ins[30:25]} << 5)
                         | ({28'd0, ins[11:8]} << 1);
            7'h37, 7'h17: imm = ins & 32'hFFFF_F000;
            7'h6F: imm = (sext << 20) | (ins & 32'h000F_F000) | ({31'd0, ins[20]} << 11)
                         | ({22'd0, ins[30:21]} << 1);
            default: imm = (sext << 11) | {21'd0, ins[30:20]};
        endcase
    endfunction

    function automatic bit m_clr(input int r);
        return wb_valid && wb_rd == r && r != 0;
    endfunction

    function automatic bit m_if_ready();
        bit u1, u2, wr, hz;
        bit [31:0] imm;
        int rs1, rs2, rd;
        mdec(if_instr, u1, u2, wr, imm);
        rs1 = if_instr[19:15]; rs2 = if_instr[24:20]; rd = if_instr[11:7];
        hz = if_valid && ((u1 && m_busy[rs1] && !m_clr(rs1)) ||
                          (u2 && m_busy[rs2] && !m_clr(rs2)) ||
                          (wr && m_busy[rd]  && !m_clr(rd)));
        return !flush && !hz && (!m_valid || ex_ready);
    endfunction

    // Compare process: checks every cycle, then advances the model by the
    // rules for the upcoming edge using the inputs now stable on the bus.
    always @(negedge clk) begin
        bit rdy, u1, u2, wr;
        bit [31:0] imm;
        if (model_ok) begin
            chk("ex_valid",   ex_valid,   m_valid);
            chk("ex_pc",      ex_pc,      m_ex.pc);
            chk("ex_instr",   ex_instr,   m_ex.instr);
            chk("ex_rs1_val", ex_rs1_val, m_ex.rs1v);
            chk("ex_rs2_val", ex_rs2_val, m_ex.rs2v);
            chk("ex_imm",     ex_imm,     m_ex.imm);
            chk("ex_rd",      ex_rd,      m_ex.rd);
            chk("ex_wen",     ex_wen,     m_ex.wen);
            chk("busy",       dut.busy,   busy_vec());
            chk("rf_raddr1",  rf_raddr1,  if_instr[19:15]);
            chk("rf_raddr2",  rf_raddr2,  if_instr[24:20]);
            chk("if_ready",   if_ready,   m_if_ready());
        end
        if (rst) begin
            model_ok = 1;
            m_valid  = 0;
            m_ex     = '{default: 0};
            foreach (m_busy[i]) m_busy[i] = 0;
        end else if (model_ok) begin
            rdy = m_if_ready();
            mdec(if_instr, u1, u2, wr, imm);
            if (wb_valid) m_busy[wb_rd] = 0;
            if (flush && m_valid && !ex_ready && m_ex.wen) m_busy[m_ex.rd] = 0;
            if (if_valid && rdy && wr) m_busy[if_instr[11:7]] = 1;
            m_busy[0] = 0;
            if (flush) m_valid = 0;
            else if (if_valid && rdy) begin
                m_valid = 1;
                m_ex = '{pc: if_pc, instr: if_instr, rs1v: rf_rdata1, rs2v: rf_rdata2,
                         imm: imm, rd: if_instr[11:7], wen: wr};
            end else if (m_valid && ex_ready) m_valid = 0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [6:0]  opc_tab [10];
    logic [31:0] b2b [4];

    initial begin
        opc_tab = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        b2b     = '{32'h00100393, 32'h00100413, 32'h00100493, 32'h00100513};

        rst = 1; if_valid = 0; if_instr = 0; if_pc = 0; rf_rdata1 = 0; rf_rdata2 = 0;
        wb_valid = 0; wb_rd = 0; flush = 0; ex_ready = 0;
        repeat (3) tick();
        rst = 0;
        chk("reset ex_valid", ex_valid, 0);
        chk("reset ex_imm",   ex_imm,   0);
        chk("reset busy",     dut.busy, 0);

        // ADDI x1,x0,5 @0x100
        if_valid = 1; if_instr = 32'h00500093; if_pc = 32'h100;
        #1 chk("addi if_ready", if_ready, 1);
        tick();
        chk("addi ex_valid", ex_valid, 1);
        chk("addi ex_imm",   ex_imm,   5);
        chk("addi ex_rd",    ex_rd,    1);
        chk("addi ex_wen",   ex_wen,   1);
        chk("addi ex_pc",    ex_pc,    32'h100);
        chk("addi busy1",    dut.busy[1], 1);

        // ADD x3,x1,x2: stalls on x1 until writeback of x1 arrives
        if_instr = 32'h002081B3; if_pc = 32'h104; ex_ready = 1;
        #1 chk("raw stall", if_ready, 0);
        tick();
        wb_valid = 1; wb_rd = 1; rf_rdata1 = 32'hAAAA5555; rf_rdata2 = 32'h12345678;
        #1 chk("raw clear ready", if_ready, 1);
        tick();
        wb_valid = 0;
        chk("add ex_valid",  ex_valid,   1);
        chk("add bypass",    ex_rs1_val, 32'hAAAA5555);
        chk("add ex_rd",     ex_rd,      3);
        chk("add busy",      dut.busy,   32'h0000_0008);

        // Execute stall holds the bundle
        ex_ready = 0; if_instr = 32'h00700213; if_pc = 32'h108;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall if_ready", if_ready, 0);
            chk("stall ex_instr", ex_instr, 32'h002081B3);
            tick();
        end
        ex_ready = 1;
        #1 chk("unstall if_ready", if_ready, 1);
        tick();
        chk("unstall ex_instr", ex_instr, 32'h00700213);

        // Flush kills a stalled x5 writer and releases its busy bit
        if_instr = 32'h00100293; if_pc = 32'h10C;
        tick();
        chk("x5 ex_rd", ex_rd, 5);
        ex_ready = 0; flush = 1; if_instr = 32'h00100313; if_pc = 32'h110;
        #1 chk("flush if_ready", if_ready, 0);
        tick();
        flush = 0; if_valid = 0;
        chk("flush ex_valid", ex_valid, 0);
        chk("flush busy",     dut.busy, 32'h0000_0018);

        // BEQ x0,x0,-4: instr[7]=1 supplies imm[11], giving -4
        if_valid = 1; if_instr = 32'hFE000EE3; if_pc = 32'h200; ex_ready = 1;
        tick();
        chk("beq ex_imm", ex_imm,  32'hFFFF_FFFC);
        chk("beq ex_wen", ex_wen,  0);
        chk("beq busy",   dut.busy, 32'h0000_0018);
        if_instr = 32'h00000013;
        tick();
        chk("nop ex_wen", ex_wen,  0);
        chk("nop busy",   dut.busy, 32'h0000_0018);

        // Back-to-back independent ADDIs
        for (int i = 0; i < 4; i++) begin
            if_instr = b2b[i];
            #1 chk("b2b if_ready", if_ready, 1);
            tick();
            chk("b2b ex_valid", ex_valid, 1);
            chk("b2b ex_rd",    ex_rd,    5'(i + 7));
        end

        // Randomized traffic checked by the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] w;
            w = $urandom;
            w[6:0]   = opc_tab[$urandom_range(0, 9)];
            w[11:7]  = 5'($urandom_range(0, 7));
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            if_instr  = w;
            if_pc     = $urandom;
            if_valid  = ($urandom_range(0, 3) != 0);
            rf_rdata1 = $urandom;
            rf_rdata2 = $urandom;
            wb_valid  = $urandom_range(0, 1);
            wb_rd     = 5'($urandom_range(0, 7));
            ex_ready  = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
